// File: rtl/gray_wr_ptr_ctrl.sv
// Write-side controller for a gray-coded FIFO pointer: req/ack write acceptance,
// binary/gray write pointer, synchronised read pointer and registered full/level flags.
`timescale 1ns/1ps
module gray_wr_ptr_ctrl #(
  parameter int K           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_req,
  output logic         wr_ack,
  output logic         mem_we,
  output logic [K-1:0] wr_addr,
  output logic [K:0]   wr_ptr_gray,
  input  logic [K:0]   rd_ptr_gray,
  output logic         full,
  output logic         almost_full,
  output logic [K:0]   level,
  output logic         ready
);

  localparam int            CW        = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] INIT_LAST = CW'(SYNC_STAGES);
  localparam logic [K:0]    AF_LEVEL  = (K+1)'((1 << K) - AF_MARGIN);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] init_cnt_q, init_cnt_d;
  logic          ready_q, ready_d;
  logic [K:0]    wr_bin_q, wr_bin_d;
  logic [K:0]    wr_gray_q, wr_gray_d;
  logic [K:0]    level_q, level_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic [K:0]    sync_q [SYNC_STAGES];
  logic [K:0]    rs_gray_s;
  logic [K:0]    rd_bin_s;
  logic          accept_s;

  function automatic logic [K:0] bin2gray(input logic [K:0] b);
    return b ^ (b >> 1);
  endfunction

  // MSB-first prefix XOR.
  function automatic logic [K:0] gray2bin(input logic [K:0] g);
    logic [K:0] b;
    b[K] = g[K];
    for (int i = K - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Init sequencing: hold off writes until the read-pointer sync chain has refilled.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
        ready_d    = 1'b0;
      end
    endcase
  end

  // Pointer advance and flags, all computed from the next-state write pointer.
  always_comb begin
    accept_s = ready_q & wr_req & ~full_q;
    if (accept_s) begin
      wr_bin_d = wr_bin_q + (K+1)'(1);
    end else begin
      wr_bin_d = wr_bin_q;
    end
    wr_gray_d = bin2gray(wr_bin_d);
    rs_gray_s = sync_q[SYNC_STAGES-1];
    rd_bin_s  = gray2bin(rs_gray_s);
    full_d    = (wr_gray_d == {~rs_gray_s[K:K-1], rs_gray_s[K-2:0]});
    level_d   = wr_bin_d - rd_bin_s;
    af_d      = (level_d >= AF_LEVEL);
  end

  // Control and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      level_q    <= level_d;
      full_q     <= full_d;
      af_q       <= af_d;
    end
  end

  // Read-pointer synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wr_ack      = accept_s;
  assign mem_we      = accept_s;
  assign wr_addr     = wr_bin_q[K-1:0];
  assign wr_ptr_gray = wr_gray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign level       = level_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_gray_wr_ptr_ctrl.sv
// Directed and randomised checks of gray_wr_ptr_ctrl with K=3, SYNC_STAGES=2, AF_MARGIN=2.
`timescale 1ns/1ps
module tb_gray_wr_ptr_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_req;
  logic       wr_ack;
  logic       mem_we;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr_gray;
  logic [3:0] rd_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] level;
  logic       ready;

  int n_cmp = 0;
  int n_bad = 0;

  gray_wr_ptr_ctrl #(.K(3), .SYNC_STAGES(2), .AF_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_ack(wr_ack), .mem_we(mem_we),
    .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
    .full(full), .almost_full(almost_full), .level(level), .ready(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ack"},   32'(wr_ack), 32'd0);
    check_eq({tag, "_we"},    32'(mem_we), 32'd0);
    check_eq({tag, "_addr"},  32'(wr_addr), 32'd0);
    check_eq({tag, "_gray"},  32'(wr_ptr_gray), 32'd0);
    check_eq({tag, "_full"},  32'(full), 32'd0);
    check_eq({tag, "_af"},    32'(almost_full), 32'd0);
    check_eq({tag, "_level"}, 32'(level), 32'd0);
    check_eq({tag, "_ready"}, 32'(ready), 32'd0);
  endtask

  logic [3:0] gseq [9];
  logic [3:0] prev_g, cur_g;
  logic [3:0] wcnt, rcnt, s1, s2, exp_level;
  logic       ack_obs, wrap_seen, exp_ack;
  int         nacks, waited, rd_pct;

  initial begin
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
             4'b0111, 4'b0101, 4'b0100, 4'b1100};
    rst = 1'b1;
    wr_req = 1'b1;
    rd_ptr_gray = 4'b0000;
    #1;
    check_all_zero("reset");

    // Test 1: init phase holds off writes for three cycles.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      check_eq("t1_ready_low", 32'(ready), 32'd0);
      check_eq("t1_ack_low",   32'(wr_ack), 32'd0);
      check_eq("t1_gray_hold", 32'(wr_ptr_gray), 32'd0);
    end
    @(negedge clk);
    check_eq("t1_ready_c4", 32'(ready), 32'd1);
    check_eq("t1_ack_c4",   32'(wr_ack), 32'd1);

    // Test 2: fill from empty with rd pointer at 0.
    nacks = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      check_eq("t2_level", 32'(level), 32'(nacks));
      check_eq("t2_af",    32'(almost_full), 32'(nacks >= 6));
      check_eq("t2_full",  32'(full), 32'(nacks == 8));
      check_eq("t2_gray",  32'(wr_ptr_gray), 32'(gseq[nacks]));
      check_eq("t2_we",    32'(mem_we), 32'(wr_ack));
      if (wr_ack) begin
        check_eq("t2_addr", 32'(wr_addr), 32'(nacks));
        nacks++;
      end
    end
    check_eq("t2_nacks", 32'(nacks), 32'd8);

    // Test 3: one read frees one slot after the synchroniser latency.
    wr_req = 1'b0;
    rd_ptr_gray = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_eq("t3_full",  32'(full),  32'(c < 3));
      check_eq("t3_level", 32'(level), (c < 3) ? 32'd8 : 32'd7);
    end
    wr_req = 1'b1;
    #1;
    check_eq("t3_ack",  32'(wr_ack), 32'd1);
    check_eq("t3_addr", 32'(wr_addr), 32'd0);
    @(posedge clk);
    #1 wr_req = 1'b0;
    @(negedge clk);
    check_eq("t3_gray",  32'(wr_ptr_gray), 32'b1101);
    check_eq("t3_full2", 32'(full), 32'd1);
    check_eq("t3_lvl2",  32'(level), 32'd8);

    // Test 4: reader follows writer through the pointer wrap.
    rd_ptr_gray = 4'b1101;
    repeat (4) @(negedge clk);
    check_eq("t4_level0", 32'(level), 32'd0);
    check_eq("t4_full0",  32'(full), 32'd0);
    @(posedge clk);
    #1 wr_req = 1'b1;
    nacks = 0;
    wrap_seen = 1'b0;
    prev_g = wr_ptr_gray;
    for (int c = 0; c < 40 && nacks < 16; c++) begin
      @(negedge clk);
      cur_g = wr_ptr_gray;
      if (cur_g != prev_g) begin
        check_eq("t4_onebit", 32'($countones(cur_g ^ prev_g)), 32'd1);
        if (prev_g == 4'b1000 && cur_g == 4'b0000) wrap_seen = 1'b1;
      end
      prev_g = cur_g;
      check_eq("t4_nofull", 32'(full), 32'd0);
      rd_ptr_gray = cur_g;
      if (wr_ack) nacks++;
    end
    @(posedge clk);
    #1 wr_req = 1'b0;
    @(negedge clk);
    check_eq("t4_nacks", 32'(nacks), 32'd16);
    check_eq("t4_last_onebit", 32'($countones(wr_ptr_gray ^ prev_g)), 32'd1);
    check_eq("t4_wrap", 32'(wrap_seen), 32'd1);
    check_eq("t4_gray_end", 32'(wr_ptr_gray), 32'b1101);

    // Test 5: asynchronous reset in the middle of a burst.
    rd_ptr_gray = wr_ptr_gray;
    @(posedge clk);
    #1 wr_req = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    rd_ptr_gray = 4'b0000;
    #1;
    check_all_zero("t5_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    waited = 0;
    for (int c = 0; c < 10 && !wr_ack; c++) begin
      @(negedge clk);
      waited++;
    end
    check_eq("t5_wait",  32'(waited), 32'd3);
    check_eq("t5_ack",   32'(wr_ack), 32'd1);
    check_eq("t5_addr0", 32'(wr_addr), 32'd0);

    // Test 6: random writes against a monotonic reader, scoreboard model.
    @(negedge clk);
    rst = 1'b1;
    wr_req = 1'b0;
    rd_ptr_gray = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10 && !ready; c++) @(negedge clk);
    check_eq("t6_ready", 32'(ready), 32'd1);
    wcnt = 4'd0; rcnt = 4'd0; s1 = 4'd0; s2 = 4'd0;
    ack_obs = 1'b0;
    prev_g = wr_ptr_gray;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      if (ack_obs) wcnt = wcnt + 4'd1;
      exp_level = wcnt - s2;
      s2 = s1;
      s1 = rcnt;
      #1;
      wr_req = ($urandom_range(0, 99) < 70);
      rd_pct = ((c / 1000) % 2 == 1) ? 20 : 85;
      if (rcnt != wcnt && $urandom_range(0, 99) < rd_pct) rcnt = rcnt + 4'd1;
      rd_ptr_gray = gray4(rcnt);
      @(negedge clk);
      exp_ack = wr_req & (exp_level != 4'd8);
      check_eq("t6_level", 32'(level), 32'(exp_level));
      check_eq("t6_full",  32'(full), 32'(exp_level == 4'd8));
      check_eq("t6_af",    32'(almost_full), 32'(exp_level >= 4'd6));
      check_eq("t6_ack",   32'(wr_ack), 32'(exp_ack));
      check_eq("t6_we",    32'(mem_we), 32'(exp_ack));
      check_eq("t6_noack_full", 32'(wr_ack & full), 32'd0);
      check_eq("t6_addr",  32'(wr_addr), 32'(wcnt[2:0]));
      check_eq("t6_gray",  32'(wr_ptr_gray), 32'(gray4(wcnt)));
      check_eq("t6_ham",   32'($countones(wr_ptr_gray ^ prev_g) <= 1), 32'd1);
      prev_g = wr_ptr_gray;
      ack_obs = wr_ack;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_wr_ptr_ctrl.md
Name: gray_wr_ptr_ctrl

Overview:
Source-side write controller for a gray-coded FIFO pointer.
- Accepts write requests through a req/ack handshake and issues memory write strobes and addresses.
- Maintains a (K+1)-bit binary write pointer and a registered gray copy of it for export to another domain.
- Synchronises the incoming gray read pointer internally and derives full, almost_full and fill level.
- Sits between the write-side requester and the dual-port RAM / gray pointer transfer path.

Parameters:
K, 8, address width; FIFO depth = 2^K; pointers are K+1 bits; K >= 2.
SYNC_STAGES, 2, flop stages on the incoming rd_ptr_gray; minimum 2.
AF_MARGIN, 4, almost_full asserts when level >= 2^K - AF_MARGIN; range 1..2^K-1.

Ports:
clk  in  1  single clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
wr_req  in  1  write request; may be held high.
wr_ack  out  1  combinational; high in the cycle a write is accepted.
mem_we  out  1  RAM write enable; identical to wr_ack.
wr_addr  out  K  RAM write address = wr_bin[K-1:0]; from register.
wr_ptr_gray  out  K+1  registered gray write pointer, for cross-domain transfer.
rd_ptr_gray  in  K+1  gray read pointer from the other domain; unsynchronised.
full  out  1  registered full flag.
almost_full  out  1  registered almost-full flag.
level  out  K+1  registered fill level, 0..2^K.
ready  out  1  high once the INIT phase is complete.

Behaviour:
Reset:
- rst asynchronously clears wr_bin, wr_ptr_gray, the sync chain, level, full, almost_full, ready and the init counter.
- The FSM enters INIT. Reset applies immediately with no clock edge, including mid-stream.
FSM:
- INIT: counts SYNC_STAGES+1 cycles after rst deasserts, then moves to RUN. ready is registered high on entry to RUN.
- RUN: terminal state until the next rst.
Accept and pointer update:
- accept = ready & wr_req & ~full.
- wr_ack and mem_we equal accept. Both are 0 in INIT regardless of wr_req.
- On an accepting edge: wr_bin <= wr_bin + 1, with modulo 2^(K+1) wrap.
- On the same edge: wr_ptr_gray <= (wr_bin_next >> 1) ^ wr_bin_next. wr_ptr_gray therefore changes by exactly one bit per accept, never combinationally.
- Without accept, wr_bin and wr_ptr_gray hold.
Read-pointer synchronisation:
- rd_ptr_gray passes through SYNC_STAGES flops to give rs_gray.
- rs_gray is converted gray-to-binary (MSB-first XOR prefix) to give rd_bin_s.
Flags, registered every cycle from the next-state values:
- full <= (gray(wr_bin_next) == {~rs_gray[K:K-1], rs_gray[K-2:0]}).
- level <= wr_bin_next - rd_bin_s, mod 2^(K+1).
- almost_full <= (level_next >= 2^K - AF_MARGIN).
Latency and boundary conditions:
- Latency from a rd_ptr_gray change to full/level update is SYNC_STAGES+1 cycles.
- A write accepted on the last free slot raises full on the same edge, so no overwrite is possible.
- wr_req while full: no ack, pointers hold. The request is retried automatically while held.
- A read-pointer advance and an accept in the same cycle: level reflects both on the next edge. level stays conservative (over-reports) and never under-reports.
- Wrap: bin 2^(K+1)-1 -> 0 gives gray {1,0...0} -> 0, a single-bit change. level and full remain correct across the wrap.

Test Plan:
1. K=3, SYNC_STAGES=2; release rst with wr_req=1 -> ready=0 and wr_ack=0 for 3 cycles, ready=1 on cycle 4; no pointer movement before then.
2. AF_MARGIN=2, rd_ptr_gray=0, wr_req held -> exactly 8 acks.
   - wr_addr runs 0..7.
   - wr_ptr_gray runs 0000,0001,0011,0010,0110,0111,0101,0100,1100.
   - almost_full=1 once level=6; full=1 after the 8th accept; no 9th ack.
3. From full, drive rd_ptr_gray=0001 -> full=0 and level=7 exactly 3 cycles later.
   - The next write goes to addr 0 and sets wr_ptr_gray=1101.
4. Reader tracking the writer, 16 consecutive writes -> wr_bin wraps 15->0 and wr_ptr_gray goes 1000->0000.
   - Exactly one bit changes per step throughout; full never asserts.
5. Assert rst asynchronously between clock edges during a burst -> all outputs 0 immediately.
   - INIT is re-entered and the first accept after recovery writes addr 0.
6. Random wr_req and random monotonic rd_ptr_gray, 10k cycles -> scoreboard checks all of:
   - level == writes - synced reads;
   - no accept while full;
   - wr_ptr_gray Hamming distance between consecutive values <= 1.
